// File: rtl/rblwe_decrypt.sv
// Ring-binary-LWE decryption core: d = c1*r2 + c2 in Z_q[x]/(x^N+1), then each
// coefficient of d is decoded to one message bit and streamed out serially.
module rblwe_decrypt #(
  parameter int N  = 256,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [QW-1:0] c1_in,
  input  logic [QW-1:0] c2_in,
  input  logic          r2_in,
  input  logic          start,
  output logic          message_out,
  output logic          valid
);

  localparam int IW = $clog2(N);
  localparam int LO = 2 ** (QW - 2);
  localparam int HI = 3 * (2 ** (QW - 2)) - 1;

  typedef enum logic [1:0] {IDLE, MULT, OUT} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] s_q, s_d;
  logic [IW:0]   o_q, o_d;
  logic          loaded_q, loaded_d;
  logic          valid_q, valid_d;
  logic          msg_q, msg_d;
  logic [N-1:0]  r2_q, r2_d;
  logic [QW-1:0] c1_q    [N];
  logic [QW-1:0] c1_d    [N];
  logic [QW-1:0] acc_q   [N];
  logic [QW-1:0] acc_d   [N];
  logic [QW-1:0] c1rot_q [N];
  logic [QW-1:0] c1rot_d [N];

  // A coefficient decodes to 1 when it lies closer to q/2 than to 0.
  function automatic logic decode(input logic [QW-1:0] v);
    return (v >= QW'(LO)) && (v <= QW'(HI));
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = '0;
    s_d      = s_q;
    o_d      = o_q;
    loaded_d = loaded_q;
    valid_d  = 1'b0;
    msg_d    = msg_q;
    r2_d     = r2_q;
    c1_d     = c1_q;
    acc_d    = acc_q;
    c1rot_d  = c1rot_q;

    case (state_q)
      IDLE: begin
        if (load) begin
          c1_d[idx_q]  = c1_in;
          acc_d[idx_q] = c2_in;
          r2_d[idx_q]  = r2_in;
          idx_d        = idx_q + IW'(1);
          loaded_d     = 1'b1;
        end else if (start && loaded_q) begin
          state_d  = MULT;
          s_d      = '0;
          loaded_d = 1'b0;
          c1rot_d  = c1_q;
        end
      end

      MULT: begin
        if (r2_q[s_q]) begin
          for (int k = 0; k < N; k++) begin
            acc_d[k] = acc_q[k] + c1rot_q[k];
          end
        end
        // Multiply by x modulo x^N+1: the top coefficient wraps to index 0 negated.
        c1rot_d[0] = QW'(0) - c1rot_q[N-1];
        for (int k = 1; k < N; k++) begin
          c1rot_d[k] = c1rot_q[k-1];
        end
        s_d = s_q + IW'(1);
        if (s_q == IW'(N - 1)) begin
          state_d = OUT;
          o_d     = '0;
        end
      end

      OUT: begin
        if (o_q < (IW+1)'(N)) begin
          valid_d = 1'b1;
          msg_d   = decode(acc_q[o_q[IW-1:0]]);
          o_d     = o_q + (IW+1)'(1);
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      s_q      <= '0;
      o_q      <= '0;
      loaded_q <= 1'b0;
      valid_q  <= 1'b0;
      msg_q    <= 1'b0;
      r2_q     <= '0;
      for (int k = 0; k < N; k++) begin
        c1_q[k]    <= '0;
        acc_q[k]   <= '0;
        c1rot_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      s_q      <= s_d;
      o_q      <= o_d;
      loaded_q <= loaded_d;
      valid_q  <= valid_d;
      msg_q    <= msg_d;
      r2_q     <= r2_d;
      c1_q     <= c1_d;
      acc_q    <= acc_d;
      c1rot_q  <= c1rot_d;
    end
  end

  assign valid       = valid_q;
  assign message_out = msg_q;

endmodule

// File: tb/tb_rblwe_decrypt.sv
// Directed bench for rblwe_decrypt: loads hand-built frames, collects the
// 256-bit serial message and compares it with hand-computed results.
module tb_rblwe_decrypt;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] c1_in;
  logic [7:0] c2_in;
  logic       r2_in;
  logic       start;
  logic       message_out;
  logic       valid;

  int errors = 0;
  int checks = 0;

  logic [7:0]   c1_v [256];
  logic [7:0]   c2_v [256];
  logic [255:0] r2_v;

  logic [255:0] bits;
  int           nvalid;
  int           first;

  rblwe_decrypt #(.N(256), .QW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .c1_in       (c1_in),
    .c2_in       (c2_in),
    .r2_in       (r2_in),
    .start       (start),
    .message_out (message_out),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_vecs();
    for (int k = 0; k < 256; k++) begin
      c1_v[k] = 8'h00;
      c2_v[k] = 8'h00;
    end
    r2_v = '0;
  endtask

  task automatic load_frame();
    for (int k = 0; k < 256; k++) begin
      load  = 1'b1;
      c1_in = c1_v[k];
      c2_in = c2_v[k];
      r2_in = r2_v[k];
      @(posedge clk); #1;
    end
    load  = 1'b0;
    c1_in = 8'h00;
    c2_in = 8'h00;
    r2_in = 1'b0;
  endtask

  // Raise start (sampled at window edge 1), hold it for 'hold' edges, and
  // record every valid bit seen over a fixed 800-cycle window.
  task automatic run_frame(input int hold, output logic [255:0] b,
                           output int nv, output int fst);
    b     = '0;
    nv    = 0;
    fst   = -1;
    start = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      @(posedge clk); #1;
      if (i == hold) start = 1'b0;
      if (valid) begin
        if (nv < 256) b[nv] = message_out;
        if (fst < 0) fst = i;
        nv++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    c1_in = 8'h00;
    c2_in = 8'h00;
    r2_in = 1'b0;
    start = 1'b0;

    #1;
    chk("reset_valid", 256'(valid), 256'd0);
    chk("reset_msg", 256'(message_out), 256'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Nothing loaded yet: start must be ignored.
    run_frame(800, bits, nvalid, first);
    chk("noload_nvalid", 256'(nvalid), 256'd0);

    // All coefficients at q/2 decode to ones; start held high the whole window.
    clear_vecs();
    for (int k = 0; k < 256; k++) c2_v[k] = 8'h80;
    load_frame();
    run_frame(800, bits, nvalid, first);
    chk("half_bits", bits, {256{1'b1}});
    chk("half_nvalid", 256'(nvalid), 256'd256);
    chk("half_latency", 256'(first - 1), 256'd257);

    // Decode threshold edges 0x3F/0x40/0xBF/0xC0.
    clear_vecs();
    c2_v[0] = 8'h3F;
    c2_v[1] = 8'h40;
    c2_v[2] = 8'hBF;
    c2_v[3] = 8'hC0;
    load_frame();
    run_frame(2, bits, nvalid, first);
    chk("thresh_bits", bits, 256'h6);
    chk("thresh_nvalid", 256'(nvalid), 256'd256);

    // Negacyclic wrap: x * (0xC0 x^255) = -0xC0 = 0x40 at index 0.
    clear_vecs();
    c1_v[255] = 8'hC0;
    r2_v[1]   = 1'b1;
    load_frame();
    run_frame(2, bits, nvalid, first);
    chk("wrap_bits", bits, 256'h1);
    chk("wrap_nvalid", 256'(nvalid), 256'd256);

    // Every secret bit set, c1 = 0x30: each acc lands on 0x30, decoding to 0.
    clear_vecs();
    c1_v[0] = 8'h30;
    r2_v    = {256{1'b1}};
    load_frame();
    run_frame(2, bits, nvalid, first);
    chk("allr2_bits", bits, 256'h0);
    chk("allr2_nvalid", 256'(nvalid), 256'd256);

    // Secret bits 0 and 2 with c1 = 0x50 place 0x50 at indices 0 and 2.
    clear_vecs();
    c1_v[0] = 8'h50;
    r2_v[0] = 1'b1;
    r2_v[2] = 1'b1;
    load_frame();
    run_frame(2, bits, nvalid, first);
    chk("sparse_bits", bits, 256'h5);

    // Back-to-back frame A: acc[1] = 0x30+0x20+(-0x40) = 0x10, acc[255] = 0x40.
    clear_vecs();
    c1_v[0]   = 8'h20;
    c1_v[254] = 8'h40;
    r2_v[1]   = 1'b1;
    r2_v[3]   = 1'b1;
    c2_v[1]   = 8'h30;
    load_frame();
    repeat (3) begin @(posedge clk); #1; end
    run_frame(2, bits, nvalid, first);
    chk("b2b_a_bits", bits, {1'b1, 255'h0});
    chk("b2b_a_nvalid", 256'(nvalid), 256'd256);

    // Frame B: c2[k] = k, so indices 64..191 decode to 1.
    clear_vecs();
    for (int k = 0; k < 256; k++) c2_v[k] = 8'(k);
    load_frame();
    repeat (3) begin @(posedge clk); #1; end
    run_frame(2, bits, nvalid, first);
    chk("b2b_b_bits", bits,
        256'h0000000000000000_FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF_0000000000000000);
    chk("b2b_b_nvalid", 256'(nvalid), 256'd256);
    chk("b2b_b_latency", 256'(first - 1), 256'd257);

    // Reset during output drops valid immediately and nothing resumes.
    clear_vecs();
    for (int k = 0; k < 256; k++) c2_v[k] = 8'h80;
    load_frame();
    start = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (i == 2) start = 1'b0;
    end
    chk("midout_valid_before", 256'(valid), 256'd1);
    chk("midout_msg_before", 256'(message_out), 256'd1);
    reset = 1'b0;
    #1;
    chk("midout_valid_async", 256'(valid), 256'd0);
    chk("midout_msg_async", 256'(message_out), 256'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run_frame(800, bits, nvalid, first);
    chk("after_reset_nvalid", 256'(nvalid), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
